// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10G PHY receive path.
//   block_width  : total 64b/66b block width from payload and header widths
//   SYNC_DATA    : sync header of a data block
//   SYNC_CTRL    : sync header of a control block
//   OFFSET_W     : width of the bitslip alignment offset
package eth_phy_10g_pkg;

  localparam int unsigned OFFSET_W = 7;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  function automatic int unsigned block_width(input int unsigned data_width,
                                              input int unsigned hdr_width);
    return data_width + hdr_width;
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_bitslip_aligner.sv
// Receive-side bitslip aligner: turns unaligned raw transceiver words into
// 64b/66b blocks by selecting a W-bit window at a bit offset that advances by
// one on each accepted bitslip rising edge.
//   clk, rst           : receive clock, synchronous active-high reset
//   gt_rx_data/valid   : raw transceiver word (bit 0 first on the wire)
//   serdes_rx_data/hdr : aligned payload / sync header (registered)
//   serdes_rx_valid    : aligned block valid (registered)
//   serdes_rx_bitslip  : slip request level from the PHY receiver
//   slip_offset        : current alignment offset, 0..W-1 (registered)
module eth_phy_10g_rx_bitslip_aligner
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned HDR_WIDTH    = 2,
  parameter int unsigned BIT_REVERSE  = 0,
  parameter int unsigned SLIP_HOLDOFF = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [block_width(DATA_WIDTH, HDR_WIDTH)-1:0]  gt_rx_data,
  input  logic                                           gt_rx_valid,
  output logic [DATA_WIDTH-1:0]                          serdes_rx_data,
  output logic [HDR_WIDTH-1:0]                           serdes_rx_hdr,
  output logic                                           serdes_rx_valid,
  input  logic                                           serdes_rx_bitslip,
  output logic [OFFSET_W-1:0]                            slip_offset
);

  localparam int unsigned W         = block_width(DATA_WIDTH, HDR_WIDTH);
  localparam int unsigned SEL_W     = $clog2(2 * W);
  localparam int unsigned HOLDOFF_W = 8;

  logic [W-1:0]         cur;
  logic [W-1:0]         prev;
  logic                 prev_loaded;
  logic [2*W-1:0]       window;
  logic [W-1:0]         aligned;
  logic [SEL_W-1:0]     sel;
  logic                 bitslip_q;
  logic                 slip_rise;
  logic [HOLDOFF_W-1:0] holdoff;

  // Optional bit reversal for MSB-first transceivers
  generate
    if (BIT_REVERSE != 0) begin : g_rev
      for (genvar i = 0; i < W; i++) begin : g_bit
        assign cur[i] = gt_rx_data[W-1-i];
      end
    end else begin : g_fwd
      assign cur = gt_rx_data;
    end
  endgenerate

  // Barrel select over the previous and current words
  assign window    = {cur, prev};
  assign sel       = SEL_W'(slip_offset);
  assign aligned   = window[sel +: W];
  assign slip_rise = serdes_rx_bitslip & ~bitslip_q;

  // Slip acceptance, holdoff and aligned output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slip_offset     <= '0;
      holdoff         <= '0;
      bitslip_q       <= 1'b0;
      prev            <= '0;
      prev_loaded     <= 1'b0;
      serdes_rx_data  <= '0;
      serdes_rx_hdr   <= '0;
      serdes_rx_valid <= 1'b0;
    end else begin
      bitslip_q <= serdes_rx_bitslip;

      // Rises during holdoff are dropped, not queued
      if (slip_rise && (holdoff == '0)) begin
        slip_offset <= (slip_offset == OFFSET_W'(W - 1)) ? '0
                                                         : slip_offset + OFFSET_W'(1);
        holdoff     <= HOLDOFF_W'(SLIP_HOLDOFF);
      end else if (holdoff != '0) begin
        holdoff <= holdoff - HOLDOFF_W'(1);
      end

      // Output uses the pre-update offset; a new offset applies from the next word
      if (gt_rx_valid) begin
        prev            <= cur;
        prev_loaded     <= 1'b1;
        serdes_rx_hdr   <= aligned[HDR_WIDTH-1:0];
        serdes_rx_data  <= aligned[W-1:HDR_WIDTH];
        serdes_rx_valid <= prev_loaded;
      end else begin
        serdes_rx_valid <= 1'b0;
      end
    end
  end

endmodule
